// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak round-constant generator.
package keccak_pkg;

    localparam int KECCAK_NR_MAX = 24;

    // Round-constant LFSR: x^8+x^6+x^5+x^4+1, output taken from bit 0.
    localparam logic [7:0] RC_LFSR_SEED = 8'h01;
    localparam logic [7:0] RC_LFSR_TAPS = 8'h71;

    // Lane bit positions 2^j-1 that receive LFSR output bit j of a round.
    localparam logic [5:0] RC_BIT_POS [0:6] = '{6'd0, 6'd1, 6'd3, 6'd7, 6'd15, 6'd31, 6'd63};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } rc_gen_state_t;

endpackage

// File: rtl/keccak_rc_lfsr_step.sv
// One combinational step of the round-constant LFSR.
module keccak_rc_lfsr_step (
    input  logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       bit_out
);
    import keccak_pkg::*;

    // The bit emitted by this step is the current LSB; feedback enters when
    // the MSB is shifted out.
    assign bit_out = r_in[0];
    assign r_out   = {r_in[6:0], 1'b0} ^ (r_in[7] ? RC_LFSR_TAPS : 8'h00);

endmodule

// File: rtl/keccak_rc_gen.sv
// Sequential Keccak-f[1600] round-constant producer with valid/ready output.
// NR: rounds per permutation (1..24). UNROLL: LFSR steps per clock (1 or 7).
module keccak_rc_gen #(
    parameter int NR     = 24,
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    output logic [63:0] rc,
    output logic        rc_valid,
    input  logic        rc_ready,
    output logic [4:0]  round_idx,
    output logic        rc_last,
    output logic        busy,
    output logic        done
);
    import keccak_pkg::*;

    localparam logic [2:0] J_INC      = 3'(UNROLL);
    localparam logic [4:0] LAST_ROUND = 5'(NR - 1);

    rc_gen_state_t state_reg, state_next;
    logic [7:0]    lfsr_reg, lfsr_next;
    logic [2:0]    j_reg, j_next;
    logic [63:0]   rc_reg, rc_next;
    logic [4:0]    round_reg, round_next;

    logic [7:0]    lfsr_stepped;
    logic [63:0]   gen_mask;

    // Chain of UNROLL LFSR steps; step gi produces sequence bit j+gi of the
    // current round, which lands on lane bit 2^(j+gi)-1.
    genvar gi;
    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_step
            logic [7:0]  r_in;
            logic [7:0]  r_out;
            logic        bit_out;
            logic [63:0] bit_mask;
            logic [63:0] mask_acc;

            if (gi == 0) begin : g_head
                assign r_in     = lfsr_reg;
                assign mask_acc = bit_mask;
            end else begin : g_tail
                assign r_in     = g_step[gi-1].r_out;
                assign mask_acc = g_step[gi-1].mask_acc | bit_mask;
            end

            assign bit_mask = {63'd0, bit_out} << RC_BIT_POS[j_reg + 3'(gi)];

            keccak_rc_lfsr_step u_step (
                .r_in    (r_in),
                .r_out   (r_out),
                .bit_out (bit_out)
            );
        end
    endgenerate

    assign lfsr_stepped = g_step[UNROLL-1].r_out;
    assign gen_mask     = g_step[UNROLL-1].mask_acc;

    // Next-state and datapath updates; clear overrides every other input.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        j_next     = j_reg;
        rc_next    = rc_reg;
        round_next = round_reg;
        if (clear) begin
            state_next = IDLE;
            lfsr_next  = RC_LFSR_SEED;
            j_next     = 3'd0;
            rc_next    = 64'd0;
            round_next = 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = GEN;
                        lfsr_next  = RC_LFSR_SEED;
                        j_next     = 3'd0;
                        rc_next    = 64'd0;
                        round_next = 5'd0;
                    end
                end
                GEN: begin
                    // LFSR is never reseeded between rounds: bit t of the
                    // sequence feeds round t/7.
                    lfsr_next = lfsr_stepped;
                    rc_next   = rc_reg | gen_mask;
                    j_next    = j_reg + J_INC;
                    if ((j_reg + J_INC) == 3'd7) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (rc_ready) begin
                        if (round_reg == LAST_ROUND) begin
                            state_next = DONE;
                        end else begin
                            state_next = GEN;
                            round_next = round_reg + 5'd1;
                            j_next     = 3'd0;
                            rc_next    = 64'd0;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: LFSR, step counter, constant under assembly, round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg  <= RC_LFSR_SEED;
            j_reg     <= 3'd0;
            rc_reg    <= 64'd0;
            round_reg <= 5'd0;
        end else begin
            lfsr_reg  <= lfsr_next;
            j_reg     <= j_next;
            rc_reg    <= rc_next;
            round_reg <= round_next;
        end
    end

    assign rc        = rc_reg;
    assign rc_valid  = (state_reg == HOLD);
    assign round_idx = round_reg;
    assign rc_last   = rc_valid && (round_reg == LAST_ROUND);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_keccak_rc_gen.sv
// Self-checking bench for keccak_rc_gen: three builds (UNROLL=1/NR=24,
// UNROLL=7/NR=24, UNROLL=1/NR=1) against a FIPS-202 round-constant model.
module tb_keccak_rc_gen;

    logic        clk;
    logic        rst_n;
    logic        start_v [3];
    logic        clear_v [3];
    logic        ready_v [3];
    logic [63:0] rc_v    [3];
    logic        valid_v [3];
    logic [4:0]  idx_v   [3];
    logic        last_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_rc [24];
    logic [63:0] got_rc [3][24];

    keccak_rc_gen #(.NR(24), .UNROLL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .clear(clear_v[0]),
        .rc(rc_v[0]), .rc_valid(valid_v[0]), .rc_ready(ready_v[0]),
        .round_idx(idx_v[0]), .rc_last(last_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    keccak_rc_gen #(.NR(24), .UNROLL(7)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .clear(clear_v[1]),
        .rc(rc_v[1]), .rc_valid(valid_v[1]), .rc_ready(ready_v[1]),
        .round_idx(idx_v[1]), .rc_last(last_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    keccak_rc_gen #(.NR(1), .UNROLL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .clear(clear_v[2]),
        .rc(rc_v[2]), .rc_valid(valid_v[2]), .rc_ready(ready_v[2]),
        .round_idx(idx_v[2]), .rc_last(last_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIPS-202 Algorithm 5, written on a 9-entry bit string R[0..8].
    function automatic logic fips_rc_bit(input int t);
        logic r [0:8];
        int   n;
        n = t % 255;
        if (n == 0) return 1'b1;
        for (int k = 0; k < 9; k++) r[k] = 1'b0;
        r[0] = 1'b1;
        for (int i = 1; i <= n; i++) begin
            for (int k = 8; k > 0; k--) r[k] = r[k-1];
            r[0] = 1'b0;
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
        end
        return r[0];
    endfunction

    // FIPS-202 Algorithm 6: RC[2^j-1] = rc(j+7*ir).
    function automatic logic [63:0] fips_round_constant(input int ir);
        logic [63:0] v;
        v = 64'd0;
        for (int j = 0; j < 7; j++) v[(1 << j) - 1] = fips_rc_bit(j + 7 * ir);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start device d and consume all nr constants, checking value, index,
    // rc_last, latency, stability under backpressure and the done pulse.
    task automatic run_sequence(input int d, input int nr, input int unroll,
                                input int ready_pct, input int stall_round,
                                input int stall_len, input bit spam_start);
        int          gap;
        int          cyc;
        int          hold;
        bit          stray_done;
        bit          bad_stable;
        logic [63:0] held_rc;
        gap = 1 + 7 / unroll;
        start_v[d] = 1'b1;
        ready_v[d] = 1'($urandom_range(1));
        tick();
        start_v[d] = spam_start ? 1'($urandom_range(1)) : 1'b0;
        for (int r = 0; r < nr; r++) begin
            cyc = 1;
            stray_done = 1'b0;
            while (valid_v[d] !== 1'b1 && cyc < 40) begin
                if (done_v[d] !== 1'b0) stray_done = 1'b1;
                ready_v[d] = 1'($urandom_range(1));
                if (spam_start) start_v[d] = 1'($urandom_range(1));
                tick();
                cyc++;
            end
            n_checks++;
            if (valid_v[d] !== 1'b1 || cyc != gap || stray_done) begin
                n_fail++;
                $display("FAIL latency: dut%0d round %0d valid=%b after %0d cycles done_seen=%b, required valid=1 after %0d cycles done_seen=0",
                         d, r, valid_v[d], cyc, stray_done, gap);
                if (valid_v[d] !== 1'b1) begin
                    clear_v[d] = 1'b1; start_v[d] = 1'b0; ready_v[d] = 1'b0;
                    tick();
                    clear_v[d] = 1'b0;
                    return;
                end
            end
            got_rc[d][r] = rc_v[d];
            n_checks++;
            if (rc_v[d] !== exp_rc[r] || idx_v[d] !== 5'(r) ||
                last_v[d] !== (r == nr - 1) || busy_v[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL constant: dut%0d round %0d got rc=%h idx=%0d last=%b busy=%b, required rc=%h idx=%0d last=%b busy=1",
                         d, r, rc_v[d], idx_v[d], last_v[d], busy_v[d], exp_rc[r], r, (r == nr - 1));
            end
            held_rc = rc_v[d];
            bad_stable = 1'b0;
            hold = 0;
            if (r == stall_round) begin
                hold = stall_len;
            end else if (ready_pct < 100) begin
                while (hold < 5 && $urandom_range(99) >= ready_pct) hold++;
            end
            for (int k = 0; k < hold; k++) begin
                ready_v[d] = 1'b0;
                if (spam_start) start_v[d] = 1'($urandom_range(1));
                tick();
                if (valid_v[d] !== 1'b1 || rc_v[d] !== held_rc ||
                    idx_v[d] !== 5'(r) || done_v[d] !== 1'b0) bad_stable = 1'b1;
            end
            if (hold > 0) begin
                n_checks++;
                if (bad_stable) begin
                    n_fail++;
                    $display("FAIL stall: dut%0d round %0d outputs moved during %0d-cycle stall (now valid=%b rc=%h idx=%0d), required held rc=%h idx=%0d",
                             d, r, hold, valid_v[d], rc_v[d], idx_v[d], held_rc, r);
                end
            end
            // Handshake happens at the end of this cycle.
            ready_v[d] = 1'b1;
            if (spam_start) start_v[d] = 1'($urandom_range(1));
            tick();
            $display("dut%0d round %2d rc=%h", d, r, held_rc);
            ready_v[d] = 1'($urandom_range(1));
            n_checks++;
            if (valid_v[d] !== 1'b0 || done_v[d] !== (r == nr - 1) || busy_v[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL after_handshake: dut%0d round %0d valid=%b done=%b busy=%b, required valid=0 done=%b busy=1",
                         d, r, valid_v[d], done_v[d], busy_v[d], (r == nr - 1));
            end
        end
        // Cycle after DONE: start offered in DONE must be dropped.
        start_v[d] = spam_start;
        tick();
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
        n_checks++;
        if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || valid_v[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_done: dut%0d done=%b busy=%b valid=%b, required 0 0 0",
                     d, done_v[d], busy_v[d], valid_v[d]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rc_v[d] !== 64'd0 || valid_v[d] !== 1'b0 || idx_v[d] !== 5'd0 ||
                last_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: dut%0d rc=%h valid=%b idx=%0d last=%b busy=%b done=%b, required all zero",
                         d, rc_v[d], valid_v[d], idx_v[d], last_v[d], busy_v[d], done_v[d]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_run();
        run_sequence(0, 24, 1, 100, -1, 0, 1'b0);
        n_checks++;
        if (got_rc[0][0] !== 64'h0000000000000001 || got_rc[0][1] !== 64'h0000000000008082 ||
            got_rc[0][2] !== 64'h800000000000808A || got_rc[0][3] !== 64'h8000000080008000) begin
            n_fail++;
            $display("FAIL first_rounds: got %h %h %h %h, required 0000000000000001 0000000000008082 800000000000808a 8000000080008000",
                     got_rc[0][0], got_rc[0][1], got_rc[0][2], got_rc[0][3]);
        end
        n_checks++;
        if (got_rc[0][23] !== 64'h8000000080008008) begin
            n_fail++;
            $display("FAIL round23: got %h, required 8000000080008008", got_rc[0][23]);
        end
    endtask

    task automatic test_backpressure();
        run_sequence(0, 24, 1, 60, 5, 10, 1'b0);
        n_checks++;
        if (got_rc[0][5] !== 64'h0000000080000001) begin
            n_fail++;
            $display("FAIL round5: got %h, required 0000000080000001", got_rc[0][5]);
        end
    endtask

    task automatic test_unroll7();
        run_sequence(1, 24, 7, 70, 9, 4, 1'b0);
    endtask

    task automatic test_nr1();
        run_sequence(2, 1, 1, 100, -1, 0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_sequence(0, 24, 1, 80, -1, 0, 1'b1);
    endtask

    task automatic test_clear();
        int  cyc;
        bit  stray;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        cyc = 0;
        while (!(idx_v[0] === 5'd7 && valid_v[0] === 1'b0 && busy_v[0] === 1'b1) && cyc < 200) begin
            tick();
            cyc++;
        end
        ready_v[0] = 1'b0;
        tick();
        tick();
        n_checks++;
        if (idx_v[0] !== 5'd7 || valid_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_setup: idx=%0d valid=%b busy=%b, required idx=7 valid=0 busy=1",
                     idx_v[0], valid_v[0], busy_v[0]);
        end
        clear_v[0] = 1'b1;
        tick();
        clear_v[0] = 1'b0;
        n_checks++;
        if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0 || idx_v[0] !== 5'd0 || done_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: busy=%b valid=%b idx=%0d done=%b, required 0 0 0 0",
                     busy_v[0], valid_v[0], idx_v[0], done_v[0]);
        end
        stray = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin
            n_fail++;
            $display("FAIL clear_quiet: done or busy seen after clear, required both 0");
        end
        // clear and start together: clear wins.
        clear_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        clear_v[0] = 1'b0;
        start_v[0] = 1'b0;
        tick();
        n_checks++;
        if (busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start: busy=%b, required 0", busy_v[0]);
        end
        run_sequence(0, 24, 1, 100, -1, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        int cyc;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b0;
        tick();
        start_v[0] = 1'b0;
        cyc = 0;
        while (valid_v[0] !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        n_checks++;
        if (valid_v[0] !== 1'b1 || rc_v[0] !== exp_rc[0]) begin
            n_fail++;
            $display("FAIL areset_setup: valid=%b rc=%h, required valid=1 rc=%h",
                     valid_v[0], rc_v[0], exp_rc[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_v[0] !== 1'b0 || rc_v[0] !== 64'd0 || busy_v[0] !== 1'b0 || idx_v[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b rc=%h busy=%b idx=%0d, required 0 0 0 0",
                     valid_v[0], rc_v[0], busy_v[0], idx_v[0]);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_sequence(0, 4 < 24 ? 24 : 24, 1, 100, -1, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            clear_v[d] = 1'b0;
            ready_v[d] = 1'b0;
            for (int r = 0; r < 24; r++) got_rc[d][r] = 64'd0;
        end
        for (int r = 0; r < 24; r++) exp_rc[r] = fips_round_constant(r);

        test_reset();
        test_full_run();
        test_backpressure();
        test_unroll7();
        test_nr1();
        test_ignored_start();
        test_clear();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_rc_gen.md
Name: keccak_rc_gen

Overview:
- Sequential round-constant producer for the permutation engine's iota step.
- Generates the 64-bit Keccak-f[1600] round constant for each round from the standard 8-bit LFSR (x^8+x^6+x^5+x^4+1); no ROM is used.
- Delivers one constant per round over a valid/ready handshake to the round datapath, which XORs it into lane (0,0).

Parameters:
- NR, 24, number of rounds per permutation; legal range 1..24; rounds 0..NR-1 are produced.
- UNROLL, 1, LFSR steps evaluated per clock; legal values 1 or 7 only.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new permutation's constant sequence; sampled only in IDLE.
- clear  input  1  synchronous abort; returns to IDLE from any state.
- rc  output  64  round constant for round_idx; stable while rc_valid && !rc_ready.
- rc_valid  output  1  rc holds the constant for round_idx.
- rc_ready  input  1  consumer accepts rc this cycle.
- round_idx  output  5  index of the round whose constant is presented.
- rc_last  output  1  high with rc_valid when round_idx == NR-1.
- busy  output  1  high in any state except IDLE.
- done  output  1  single-cycle pulse the cycle after the final handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lfsr=8'h01, step counter=0. Outputs: rc=0, rc_valid=0, round_idx=0, rc_last=0, busy=0, done=0.
- LFSR: state r[7:0], output bit r[0]. One step: r_next = {r[6:0],1'b0} ^ (r[7] ? 8'h71 : 8'h00).
  - r runs continuously across rounds: bit t of the sequence is rc(t).
  - Reseeded to 8'h01 on start accept and on clear.
- Constant assembly:
  - For round ir, RC[2^j-1] = rc(j+7*ir), j=0..6, i.e. bits 0,1,3,7,15,31,63.
  - All other bits are 0.
  - rc is cleared to 0 at the start of each round's GEN phase; bits are OR-ed in as steps complete.
- FSM states:
  - IDLE: start=1 -> GEN, round_idx=0, lfsr=8'h01, j=0, rc=0.
  - GEN: perform UNROLL LFSR steps per cycle, j += UNROLL. When j reaches 7 -> HOLD. GEN lasts 7/UNROLL cycles: 7 cycles for UNROLL=1, 1 cycle for UNROLL=7.
  - HOLD: rc_valid=1. On rc_ready=1:
    - if round_idx==NR-1 -> DONE;
    - else round_idx++, j=0, rc=0 -> GEN.
    rc and round_idx must not change while waiting.
  - DONE: done=1 for one cycle, then -> IDLE. round_idx and rc retain their final values; rc_valid=0.
- Latency:
  - start sampled at cycle N -> first rc_valid at N+1+7/UNROLL.
  - Handshake at cycle M -> next rc_valid at M+1+7/UNROLL.
  - There is a 7/UNROLL-cycle bubble between constants; no prefetch.
- rc_valid is registered and deasserts the cycle after a handshake.
- rc_ready while rc_valid=0 is ignored.
- start outside IDLE is ignored, including in DONE.
- clear has priority over every other input.
  - In any state: next cycle state=IDLE, rc_valid=0, busy=0, round_idx=0, lfsr=8'h01.
  - No done pulse is generated.
- clear and start in the same IDLE cycle: clear wins and start is dropped.
- Reset mid-sequence behaves exactly as a clear, but takes effect asynchronously.
- NR=1: rc_last is high on the first and only constant; done follows its handshake.

Decomposition:
- Shared package keccak_pkg holds:
  - KECCAK_NR_MAX=24;
  - RC_LFSR_SEED=8'h01, RC_LFSR_TAPS=8'h71;
  - RC_BIT_POS array {0,1,3,7,15,31,63};
  - the rc_gen state enum {IDLE,GEN,HOLD,DONE}.
- One combinational sub-module, keccak_rc_lfsr_step: r_in[7:0] -> r_out[7:0] and bit_out. Instantiated UNROLL times in a chain.

Test Plan:
- Reset, then start, rc_ready=1, UNROLL=1:
  - first rc_valid exactly 8 cycles after start;
  - round 0 rc=64'h0000000000000001, round 1=64'h0000000000008082, round 2=64'h800000000000808A, round 3=64'h8000000080008000.
- Full 24-round run:
  - all 24 constants match the FIPS-202 table; round 23=64'h8000000080008008 with rc_last=1;
  - done pulses once, the cycle after that handshake.
- Backpressure: hold rc_ready=0 for 10 cycles in round 5 -> rc=64'h0000000080000001 and round_idx=5 remain stable; one handshake on release; no round is skipped.
- UNROLL=7 build: constants identical to the UNROLL=1 run; each constant appears 2 cycles after the previous handshake.
- Assert clear while round_idx=7 is in GEN -> IDLE next cycle, busy=0, no done; a following start yields round 0 = 64'h0000000000000001.
- start while busy and start in DONE are ignored; async reset mid-HOLD drops rc_valid immediately and rc=0.
